// File: rtl/reg_select_decoder_p_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_select_decoder_p_pkg
//  Description : Shared constants for the register-select/decode unit:
//                default geometry, opcode encodings and field-offset helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_select_decoder_p_pkg;

  // Default geometry of the instruction word and register file
  localparam int c_DATA_W_DEF     = 32;
  localparam int c_OPC_W_DEF      = 5;
  localparam int c_REG_ADDR_W_DEF = 4;
  localparam int c_NUM_REGS_DEF   = 16;
  localparam int c_IMM_W_DEF      = 19;

  // Register fields are packed Ra, Rb, Rc from just below the opcode downwards
  localparam int c_FIELD_RA = 0;
  localparam int c_FIELD_RB = 1;
  localparam int c_FIELD_RC = 2;

  // Opcode encodings of the datapath instruction set
  typedef enum logic [4:0] {
    OPC_LD   = 5'd0,
    OPC_LDR  = 5'd1,
    OPC_ST   = 5'd2,
    OPC_STR  = 5'd3,
    OPC_LA   = 5'd4,
    OPC_LAR  = 5'd5,
    OPC_ADD  = 5'd12,
    OPC_SUB  = 5'd14,
    OPC_NOP  = 5'd31
  } opcode_e;

  // MSB position of register field idx (0=Ra, 1=Rb, 2=Rc) within the IR
  function automatic int field_msb(input int data_w, input int opc_w,
                                   input int reg_addr_w, input int idx);
    return data_w - opc_w - 1 - idx * reg_addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_select_decoder_p_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_select_decoder_p_if
//  Description : Control/decode bus between the datapath sequencer (master)
//                and the register-select decoder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_select_decoder_p_if
  import reg_select_decoder_p_pkg::*;
#(
  parameter int DATA_W   = c_DATA_W_DEF,
  parameter int OPC_W    = c_OPC_W_DEF,
  parameter int NUM_REGS = c_NUM_REGS_DEF
);
  logic [DATA_W-1:0]   ir_in;
  logic                ir_load;
  logic                gra;
  logic                grb;
  logic                grc;
  logic                rin;
  logic                rout;
  logic                baout;
  logic                conflict_clr;
  logic [OPC_W-1:0]    opcode;
  logic [NUM_REGS-1:0] reg_in_oh;
  logic [NUM_REGS-1:0] reg_out_oh;
  logic                ba_zero;
  logic [DATA_W-1:0]   c_sext;
  logic                sel_conflict;
  logic                addr_err;

  modport master (
    output ir_in, ir_load, gra, grb, grc, rin, rout, baout, conflict_clr,
    input  opcode, reg_in_oh, reg_out_oh, ba_zero, c_sext, sel_conflict, addr_err
  );

  modport slave (
    input  ir_in, ir_load, gra, grb, grc, rin, rout, baout, conflict_clr,
    output opcode, reg_in_oh, reg_out_oh, ba_zero, c_sext, sel_conflict, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/reg_select_decoder_p_onehot_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : reg_select_decoder_p_onehot_decoder
//  Description : Enabled binary-to-one-hot decoder for NUM_REGS registers with
//                an out-of-range indication for unimplemented addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_select_decoder_p_onehot_decoder
  import reg_select_decoder_p_pkg::*;
#(
  parameter int REG_ADDR_W = c_REG_ADDR_W_DEF,
  parameter int NUM_REGS   = c_NUM_REGS_DEF
) (
  input  wire logic [REG_ADDR_W-1:0] i_addr,
  input  wire logic                  i_en,
  output      logic [NUM_REGS-1:0]   o_onehot,
  output      logic                  o_out_of_range
);

  // Unimplemented addresses match no bit, so the output is naturally zero
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bit
    assign o_onehot[g] = i_en && (i_addr == REG_ADDR_W'(g));
  end

  // Range flag only qualifies when the decoder is actually being used
  if (NUM_REGS < (1 << REG_ADDR_W)) begin : g_partial
    assign o_out_of_range = i_en && ({1'b0, i_addr} >= (REG_ADDR_W + 1)'(NUM_REGS));
  end else begin : g_full
    assign o_out_of_range = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/reg_select_decoder_p.sv
`default_nettype none
// ============================================================================
//  Module      : reg_select_decoder_p
//  Description : Register-select/decode unit. Keeps an IR shadow, extracts
//                opcode / Ra / Rb / Rc / C, and drives one-hot register-file
//                enables for the Gra/Grb/Grc + Rin/Rout/BAout strobes, with
//                sticky selection-conflict and address-range error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_select_decoder_p
  import reg_select_decoder_p_pkg::*;
#(
  parameter int DATA_W     = c_DATA_W_DEF,
  parameter int OPC_W      = c_OPC_W_DEF,
  parameter int REG_ADDR_W = c_REG_ADDR_W_DEF,
  parameter int NUM_REGS   = c_NUM_REGS_DEF,
  parameter int IMM_W      = c_IMM_W_DEF,
  parameter int PIPE       = 0
) (
  input  wire logic         clock,
  input  wire logic         clear,
  reg_select_decoder_p_if.slave bus
);

  localparam int c_RA_MSB = field_msb(DATA_W, OPC_W, REG_ADDR_W, c_FIELD_RA);
  localparam int c_RB_MSB = field_msb(DATA_W, OPC_W, REG_ADDR_W, c_FIELD_RB);
  localparam int c_RC_MSB = field_msb(DATA_W, OPC_W, REG_ADDR_W, c_FIELD_RC);

  // Reject geometries the field layout cannot hold
  if ((NUM_REGS > (1 << REG_ADDR_W)) || (OPC_W + 3 * REG_ADDR_W > DATA_W) ||
      (IMM_W >= DATA_W)) begin : g_param_check
    $error("reg_select_decoder_p: illegal NUM_REGS/REG_ADDR_W/OPC_W/IMM_W combination");
  end

  logic [DATA_W-1:0]     r_ir;
  logic [REG_ADDR_W-1:0] w_sel;
  logic                  w_sel_valid;
  logic                  w_multi_sel;
  logic                  w_in_en;
  logic                  w_out_en;
  logic                  w_ba_r0;
  logic [NUM_REGS-1:0]   w_in_oh;
  logic [NUM_REGS-1:0]   w_out_oh;
  logic                  w_in_oor;
  logic                  w_out_oor;
  logic                  r_sel_conflict;
  logic                  r_addr_err;

  // IR shadow: reset beats a simultaneous load; decode this cycle sees the old value
  always_ff @(posedge clock) begin
    if (!clear) begin
      r_ir <= '0;
    end else if (bus.ir_load) begin
      r_ir <= bus.ir_in;
    end
  end

  // Field select with fixed priority Gra > Grb > Grc
  always_comb begin
    w_sel       = '0;
    w_sel_valid = 1'b0;
    if (bus.gra) begin
      w_sel       = r_ir[c_RA_MSB -: REG_ADDR_W];
      w_sel_valid = 1'b1;
    end else if (bus.grb) begin
      w_sel       = r_ir[c_RB_MSB -: REG_ADDR_W];
      w_sel_valid = 1'b1;
    end else if (bus.grc) begin
      w_sel       = r_ir[c_RC_MSB -: REG_ADDR_W];
      w_sel_valid = 1'b1;
    end
  end

  assign w_multi_sel = (bus.gra & bus.grb) | (bus.gra & bus.grc) | (bus.grb & bus.grc);

  // BAout on R0 means "drive zero" instead of enabling R0 onto the bus
  assign w_ba_r0  = bus.baout & w_sel_valid & (w_sel == '0);
  assign w_in_en  = bus.rin & w_sel_valid;
  assign w_out_en = w_sel_valid & (bus.rout | (bus.baout & (w_sel != '0)));

  reg_select_decoder_p_onehot_decoder #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_REGS   (NUM_REGS)
  ) u_in_dec (
    .i_addr         (w_sel),
    .i_en           (w_in_en),
    .o_onehot       (w_in_oh),
    .o_out_of_range (w_in_oor)
  );

  reg_select_decoder_p_onehot_decoder #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_REGS   (NUM_REGS)
  ) u_out_dec (
    .i_addr         (w_sel),
    .i_en           (w_out_en),
    .o_onehot       (w_out_oh),
    .o_out_of_range (w_out_oor)
  );

  // Sticky error flags: a new error in the same cycle beats the clear request
  always_ff @(posedge clock) begin
    if (!clear) begin
      r_sel_conflict <= 1'b0;
      r_addr_err     <= 1'b0;
    end else begin
      if (w_multi_sel) begin
        r_sel_conflict <= 1'b1;
      end else if (bus.conflict_clr) begin
        r_sel_conflict <= 1'b0;
      end
      if (w_in_oor | w_out_oor) begin
        r_addr_err <= 1'b1;
      end else if (bus.conflict_clr) begin
        r_addr_err <= 1'b0;
      end
    end
  end

  assign bus.sel_conflict = r_sel_conflict;
  assign bus.addr_err     = r_addr_err;
  assign bus.opcode       = r_ir[DATA_W-1 -: OPC_W];
  assign bus.c_sext       = {{(DATA_W - IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};

  if (PIPE != 0) begin : g_pipe
    logic [NUM_REGS-1:0] r_in_oh;
    logic [NUM_REGS-1:0] r_out_oh;
    logic                r_ba_zero;

    // Registered enables: follow the strobes one cycle later, no hold
    always_ff @(posedge clock) begin
      if (!clear) begin
        r_in_oh   <= '0;
        r_out_oh  <= '0;
        r_ba_zero <= 1'b0;
      end else begin
        r_in_oh   <= w_in_oh;
        r_out_oh  <= w_out_oh;
        r_ba_zero <= w_ba_r0;
      end
    end

    assign bus.reg_in_oh  = r_in_oh;
    assign bus.reg_out_oh = r_out_oh;
    assign bus.ba_zero    = r_ba_zero;
  end else begin : g_comb
    // Held idle while clear is asserted so a reset cycle never strobes a register
    assign bus.reg_in_oh  = clear ? w_in_oh  : '0;
    assign bus.reg_out_oh = clear ? w_out_oh : '0;
    assign bus.ba_zero    = clear & w_ba_r0;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_select_decoder_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_select_decoder_p
//  Description : Self-checking bench for reg_select_decoder_p: a combinational
//                instance, a pipelined instance and a 12-register instance
//                driven with identical stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_select_decoder_p;

  localparam logic [5:0] c_GRA   = 6'b100000;
  localparam logic [5:0] c_GRB   = 6'b010000;
  localparam logic [5:0] c_GRC   = 6'b001000;
  localparam logic [5:0] c_RIN   = 6'b000100;
  localparam logic [5:0] c_ROUT  = 6'b000010;
  localparam logic [5:0] c_BAOUT = 6'b000001;
  localparam logic [31:0] c_JUNK = 32'hDEAD_BEEF;

  typedef struct {
    logic        ld;
    logic [31:0] ir;
    logic [5:0]  stb;
    logic [15:0] e_in;
    logic [15:0] e_out;
    logic        e_ba;
    logic [4:0]  e_opc;
    logic [31:0] e_sext;
  } vec_t;

  logic clock;
  logic clear;
  int   n_vec;
  int   n_err;
  vec_t v[14];
  int   q[$];

  reg_select_decoder_p_if #(.DATA_W(32), .OPC_W(5), .NUM_REGS(16)) bus0 ();
  reg_select_decoder_p_if #(.DATA_W(32), .OPC_W(5), .NUM_REGS(16)) bus1 ();
  reg_select_decoder_p_if #(.DATA_W(32), .OPC_W(5), .NUM_REGS(12)) bus2 ();

  reg_select_decoder_p #(.NUM_REGS(16), .PIPE(0)) u_dut0 (.clock(clock), .clear(clear), .bus(bus0));
  reg_select_decoder_p #(.NUM_REGS(16), .PIPE(1)) u_dut1 (.clock(clock), .clear(clear), .bus(bus1));
  reg_select_decoder_p #(.NUM_REGS(12), .PIPE(0)) u_dut2 (.clock(clock), .clear(clear), .bus(bus2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [31:0] ir, input logic [5:0] stb,
                       input logic cclr);
    bus0.ir_load = ld; bus1.ir_load = ld; bus2.ir_load = ld;
    bus0.ir_in   = ir; bus1.ir_in   = ir; bus2.ir_in   = ir;
    {bus0.gra, bus0.grb, bus0.grc, bus0.rin, bus0.rout, bus0.baout} = stb;
    {bus1.gra, bus1.grb, bus1.grc, bus1.rin, bus1.rout, bus1.baout} = stb;
    {bus2.gra, bus2.grb, bus2.grc, bus2.rin, bus2.rout, bus2.baout} = stb;
    bus0.conflict_clr = cclr; bus1.conflict_clr = cclr; bus2.conflict_clr = cclr;
  endtask

  // Pipelined instance: compare the oldest outstanding expectation
  task automatic pop_pipe();
    int k;
    if (q.size() > 0) begin
      k = q.pop_front();
      chk($sformatf("v%0d pipe in", k),  32'(bus1.reg_in_oh),  32'(v[k].e_in));
      chk($sformatf("v%0d pipe out", k), 32'(bus1.reg_out_oh), 32'(v[k].e_out));
      chk($sformatf("v%0d pipe ba", k),  32'(bus1.ba_zero),    32'(v[k].e_ba));
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    // IR 0x0A980000: opcode 1, Ra 5, Rb 3, Rc 0; 0x0A9C0000 adds Rc 8 / C sign bit
    v[0]  = '{1'b1, 32'h0A98_0000, c_GRA | c_RIN,          16'h0001, 16'h0000, 1'b0, 5'd0, 32'h0000_0000};
    v[1]  = '{1'b0, c_JUNK,        c_GRA | c_RIN,          16'h0020, 16'h0000, 1'b0, 5'd1, 32'h0000_0000};
    v[2]  = '{1'b0, c_JUNK,        c_GRB | c_ROUT,         16'h0000, 16'h0008, 1'b0, 5'd1, 32'h0000_0000};
    v[3]  = '{1'b0, c_JUNK,        c_GRC | c_BAOUT,        16'h0000, 16'h0000, 1'b1, 5'd1, 32'h0000_0000};
    v[4]  = '{1'b0, c_JUNK,        c_GRC | c_ROUT,         16'h0000, 16'h0001, 1'b0, 5'd1, 32'h0000_0000};
    v[5]  = '{1'b0, c_JUNK,        c_RIN | c_ROUT,         16'h0000, 16'h0000, 1'b0, 5'd1, 32'h0000_0000};
    v[6]  = '{1'b0, c_JUNK,        c_GRA | c_RIN | c_ROUT, 16'h0020, 16'h0020, 1'b0, 5'd1, 32'h0000_0000};
    v[7]  = '{1'b0, c_JUNK,        c_GRA | c_BAOUT,        16'h0000, 16'h0020, 1'b0, 5'd1, 32'h0000_0000};
    v[8]  = '{1'b1, 32'h0000_0005, c_GRB | c_ROUT,         16'h0000, 16'h0008, 1'b0, 5'd1, 32'h0000_0000};
    v[9]  = '{1'b0, c_JUNK,        c_GRA | c_ROUT,         16'h0000, 16'h0001, 1'b0, 5'd0, 32'h0000_0005};
    v[10] = '{1'b0, c_JUNK,        6'b000000,              16'h0000, 16'h0000, 1'b0, 5'd0, 32'h0000_0005};
    v[11] = '{1'b1, 32'h0A9C_0000, 6'b000000,              16'h0000, 16'h0000, 1'b0, 5'd0, 32'h0000_0005};
    v[12] = '{1'b0, c_JUNK,        c_GRC | c_ROUT,         16'h0000, 16'h0100, 1'b0, 5'd1, 32'hFFFC_0000};
    v[13] = '{1'b0, c_JUNK,        c_GRB | c_BAOUT | c_RIN,16'h0008, 16'h0008, 1'b0, 5'd1, 32'hFFFC_0000};

    // Reset with a load and strobes pending: reset must win, outputs idle
    clear = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, c_GRA | c_RIN | c_ROUT, 1'b0);
    repeat (3) @(negedge clock);
    chk("rst dut0 in",    32'(bus0.reg_in_oh),  32'h0);
    chk("rst dut0 out",   32'(bus0.reg_out_oh), 32'h0);
    chk("rst dut0 opc",   32'(bus0.opcode),     32'h0);
    chk("rst dut0 sext",  bus0.c_sext,          32'h0);
    chk("rst dut1 in",    32'(bus1.reg_in_oh),  32'h0);
    chk("rst dut1 out",   32'(bus1.reg_out_oh), 32'h0);
    chk("rst dut0 conf",  32'(bus0.sel_conflict), 32'h0);
    chk("rst dut2 aerr",  32'(bus2.addr_err),   32'h0);
    drive(1'b0, 32'h0, 6'b000000, 1'b0);
    clear = 1'b1;

    // Table vectors, one per cycle
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      pop_pipe();
      drive(v[i].ld, v[i].ir, v[i].stb, 1'b0);
      #2;
      chk($sformatf("v%0d dut0 in", i),   32'(bus0.reg_in_oh),  32'(v[i].e_in));
      chk($sformatf("v%0d dut0 out", i),  32'(bus0.reg_out_oh), 32'(v[i].e_out));
      chk($sformatf("v%0d dut0 ba", i),   32'(bus0.ba_zero),    32'(v[i].e_ba));
      chk($sformatf("v%0d dut0 opc", i),  32'(bus0.opcode),     32'(v[i].e_opc));
      chk($sformatf("v%0d dut0 sext", i), bus0.c_sext,          v[i].e_sext);
      chk($sformatf("v%0d dut2 in", i),   32'(bus2.reg_in_oh),  32'(v[i].e_in[11:0]));
      chk($sformatf("v%0d dut2 out", i),  32'(bus2.reg_out_oh), 32'(v[i].e_out[11:0]));
      q.push_back(i);
    end
    @(negedge clock);
    pop_pipe();
    drive(1'b0, 32'h0, 6'b000000, 1'b0);
    chk("tbl dut0 conf", 32'(bus0.sel_conflict), 32'h0);
    chk("tbl dut2 aerr", 32'(bus2.addr_err),     32'h0);

    // Multiple field selects: priority holds, conflict flag is sticky
    drive(1'b0, 32'h0, c_GRA | c_GRB | c_RIN, 1'b0);
    #2;
    chk("conf in",       32'(bus0.reg_in_oh),    32'h0020);
    chk("conf pre",      32'(bus0.sel_conflict), 32'h0);
    @(negedge clock);
    chk("conf set",      32'(bus0.sel_conflict), 32'h1);
    drive(1'b0, 32'h0, 6'b000000, 1'b0);
    @(negedge clock);
    chk("conf hold",     32'(bus0.sel_conflict), 32'h1);
    chk("conf dut1 hold",32'(bus1.sel_conflict), 32'h1);
    drive(1'b0, 32'h0, 6'b000000, 1'b1);
    @(negedge clock);
    chk("conf cleared",  32'(bus0.sel_conflict), 32'h0);
    drive(1'b0, 32'h0, c_GRA | c_GRC | c_RIN, 1'b1);
    @(negedge clock);
    chk("conf set wins", 32'(bus0.sel_conflict), 32'h1);
    drive(1'b0, 32'h0, 6'b000000, 1'b1);
    @(negedge clock);
    chk("conf clr2",     32'(bus0.sel_conflict), 32'h0);

    // Ra=13 is out of range only for the 12-register instance
    drive(1'b1, 32'h0680_0000, 6'b000000, 1'b0);
    @(negedge clock);
    drive(1'b0, 32'h0, c_GRA | c_ROUT, 1'b0);
    #2;
    chk("oor dut2 out",   32'(bus2.reg_out_oh), 32'h0);
    chk("oor dut2 pre",   32'(bus2.addr_err),   32'h0);
    chk("oor dut0 out",   32'(bus0.reg_out_oh), 32'h2000);
    @(negedge clock);
    chk("oor dut2 aerr",  32'(bus2.addr_err),   32'h1);
    chk("oor dut0 aerr",  32'(bus0.addr_err),   32'h0);
    chk("oor dut1 out",   32'(bus1.reg_out_oh), 32'h2000);

    // Reset in the middle of an active strobe
    clear = 1'b0;
    #2;
    chk("mid dut0 out",   32'(bus0.reg_out_oh), 32'h0);
    @(negedge clock);
    chk("mid dut1 out",   32'(bus1.reg_out_oh), 32'h0);
    chk("mid dut2 aerr",  32'(bus2.addr_err),   32'h0);
    chk("mid dut0 opc",   32'(bus0.opcode),     32'h0);
    chk("mid dut0 in",    32'(bus0.reg_in_oh),  32'h0);
    drive(1'b0, 32'h0, 6'b000000, 1'b0);
    clear = 1'b1;
    @(negedge clock);
    chk("post dut1 out",  32'(bus1.reg_out_oh), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
